// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- 8-requester round-robin arbiter with hold-until-release grants.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req[7:0]      in   request vector, bit i = requester i wants the resource
//   gnt[7:0]      out  registered one-hot grant, zero when idle
//   gnt_idx[2:0]  out  registered encoded index of the owner, zero when idle
//   gnt_valid     out  registered, high while a grant is active
//   timeout_pulse out  one-cycle pulse on forced preemption (0 without the macro)
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner that has held the grant for MAX_HOLD cycles while
//   another requester is pending is preempted as if it had released.
//
// Handshake: req[i] is a level request. Once gnt[i] is high the grant stays
// with requester i for as long as req[i] is sampled high on rising edges; the
// first edge sampling req[i] low is the release. There is no ready/ack path.
//
// The FSM state is held in the internal signal `state` (IDLE/GRANT) so that
// checkers can bind to it hierarchically.

module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout_pulse
);

  // Elaboration-time guards on the supported configuration.
  if (N != 8) begin : g_bad_n
    $error("rr_arbiter_8: only N=8 is supported");
  end
  if (IDXW != 3) begin : g_bad_idxw
    $error("rr_arbiter_8: IDXW must equal log2(N)=3");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must lie in 2..255");
  end

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state, state_n;
  logic [IDXW-1:0] ptr, ptr_n;
  logic [N-1:0]    gnt_n;
  logic [IDXW-1:0] gnt_idx_n;
  logic            gnt_valid_n;

  // Circular search starting at base. Returns {found, index}. The loop runs
  // from the farthest position back to base so the closest hit is the one
  // left in the result.
  function automatic logic [IDXW:0] rr_search(input logic [N-1:0]    r,
                                              input logic [IDXW-1:0] base);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] pos;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = base + k[IDXW-1:0];
      if (r[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  logic [IDXW:0]   srch_idle;
  logic [IDXW:0]   srch_next;
  logic [IDXW-1:0] ptr_after;   // pointer one past the current owner
  logic            owner_req;
  logic            handoff;     // owner leaves this edge (release or preemption)

  assign ptr_after = gnt_idx + 1'b1;
  assign owner_req = req[gnt_idx];
  assign srch_idle = rr_search(req, ptr);
  assign srch_next = rr_search(req, ptr_after);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_cnt_n;
  logic       preempt;
  logic       timeout_pulse_n;
  logic       others_pending;

  assign others_pending = |(req & ~gnt);
  assign preempt = (state == GRANT) && owner_req && others_pending &&
                   (hold_cnt == 8'(MAX_HOLD - 1));
  assign handoff = !owner_req || preempt;
`else
  assign handoff = !owner_req;
`endif

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    case (state)
      IDLE: begin
        if (srch_idle[IDXW]) begin
          state_n     = GRANT;
          gnt_n       = onehot(srch_idle[IDXW-1:0]);
          gnt_idx_n   = srch_idle[IDXW-1:0];
          gnt_valid_n = 1'b1;
        end
      end
      GRANT: begin
        if (handoff) begin
          // The leaving owner gets lowest priority in the next search.
          ptr_n = ptr_after;
          if (srch_next[IDXW]) begin
            gnt_n       = onehot(srch_next[IDXW-1:0]);
            gnt_idx_n   = srch_next[IDXW-1:0];
            gnt_valid_n = 1'b1;
          end else begin
            state_n     = IDLE;
            gnt_n       = '0;
            gnt_idx_n   = '0;
            gnt_valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n     = IDLE;
        gnt_n       = '0;
        gnt_idx_n   = '0;
        gnt_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // hold_cnt counts edges the current owner has kept the grant; any new
  // grant (from IDLE or by handoff) restarts it at 0.
  always_comb begin
    hold_cnt_n      = hold_cnt;
    timeout_pulse_n = 1'b0;
    if (state_n != GRANT) begin
      hold_cnt_n = '0;
    end else if (state == IDLE || handoff) begin
      hold_cnt_n      = '0;
      timeout_pulse_n = preempt;
    end else if (hold_cnt != 8'hFF) begin
      hold_cnt_n = hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      hold_cnt      <= hold_cnt_n;
      timeout_pulse <= timeout_pulse_n;
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter that grants exclusive ownership of a shared resource to one requester at a time.
- Emits the grant as one-hot `gnt` plus its encoded 3-bit index, so the index can drive a downstream mux or other shared-resource select directly.
- Grants are held until the owner releases. The pointer then rotates so that every requester is served within 8 grant turns.

Parameters:
- N, 8, number of requesters; only 8 supported.
- IDXW, 3, width of `gnt_idx`; equals log2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i high = requester i wants the resource.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_idx  output  3  registered encoded index of the current owner; 0 when idle.
- gnt_valid  output  1  registered; high while any grant is active.
- timeout_pulse  output  1  one-cycle pulse on forced preemption; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout_pulse`=0, internal `ptr`=0, `hold_cnt`=0, state=IDLE.
- Reset asserted mid-grant clears all outputs immediately, without waiting for `clk`.
- Search function: first i in the circular order ptr, ptr+1, …, 7, 0, …, ptr-1 with req[i]=1.
- State IDLE:
  - If req != 0, the next edge loads `gnt`=onehot(i), `gnt_idx`=i, `gnt_valid`=1 and goes to GRANT.
  - Latency from req asserting to the grant appearing is 1 clock.
- State GRANT, owner o:
  - req[o]=1: hold all outputs unchanged; `hold_cnt` increments, saturating at 255.
  - req[o]=0 (release):
    - Set `ptr`=(o+1) mod 8, wrapping 7→0.
    - At the same edge, search using the new ptr. If a requester is found, grant it directly (no idle bubble) and stay in GRANT with `hold_cnt`=0.
    - If no requester is found, clear `gnt`, `gnt_idx` and `gnt_valid`, and go to IDLE.
- Fairness: the releasing requester has lowest priority in the next search. Every requester waits at most 7 grant turns.
- Simultaneous events:
  - New requests arriving during a grant are only registered for the next search; they never preempt (except via timeout).
  - If the owner drops and re-raises req between edges, it is invisible: only sampled values count.
- req bits toggling while not granted are allowed; no req latching is done.
- Invariants:
  - `gnt` is always 0 or one-hot.
  - `gnt_idx` is always the encoding of `gnt`.
  - `gnt_valid` is always the OR of `gnt`.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when `hold_cnt`=MAX_HOLD-1 and another requester is pending, the next edge treats the owner as released: `ptr`=(o+1) mod 8, re-search, grant the found requester.
  - `timeout_pulse`=1 for exactly that one cycle.
  - The preempted owner keeps requesting and is served again in normal round-robin order.
  - If no other requester is pending, the owner keeps the grant and `hold_cnt` saturates.
- Undefined: no preemption, `hold_cnt` logic is omitted, `timeout_pulse` is tied to 0.

Test Plan:
- Reset with req=8'hFF, then release rst_n → first edge gives `gnt`=8'h01, `gnt_idx`=0, `gnt_valid`=1. Then assert rst_n=0 mid-cycle → all outputs 0 immediately.
- Single requester: req=8'h08 → 1 cycle later `gnt`=8'h08, `gnt_idx`=3. Drop req → next edge `gnt`=0, `gnt_valid`=0.
- Rotation: req=8'hFF, each owner drops its bit for one cycle after being granted → grant order is idx 0,1,2,…,7,0 with no idle cycles between grants.
- Wrap-around: owner idx 6 with req=8'h41 → 6 releases → next grant is idx 0, not 6 again.
- Hold: req=8'h05, owner 0 holds for 20 cycles → `gnt` stays 8'h01 with 2 pending. Owner releases → `gnt`=8'h04.
- ARB_TIMEOUT_EN, MAX_HOLD=16:
  - req=8'h03, both held high → grants alternate 0,1,0 every 16 cycles, with a `timeout_pulse` at each switch.
  - With req=8'h01 only → no pulse and the grant is held indefinitely.
